flag_register_unit: RTL

- Sits directly downstream of the 64-bit ALU result/zero-detect path and registers the result, carry and overflow.
- Derives N and Z from the registered result, then commits them with C and V into an architectural NZCV flag register.
- Evaluates ARM-style condition codes against the committed flags for B.cond.
- Raises a stall while a flag update is still in flight.

---
 rtl/flag_register_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/flag_register_unit.sv
// NZCV flag register fed by the ALU: capture stage, commit stage and
// B.cond evaluation against the committed flags, with stall while an update is in flight.
module flag_register_unit #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             alu_valid,
    input  logic             set_flags,
    input  logic             cond_req,
    input  logic [3:0]       cond_code,
    output logic [3:0]       flags,
    output logic             stall,
    output logic             cond_valid,
    output logic             cond_taken
);

    localparam int unsigned LEVELS = (WIDTH <= 4) ? 1 : (($clog2(WIDTH) + 1) / 2);
    localparam int unsigned PAD    = 1 << (2 * LEVELS);

    // Offset of tree level k inside the flat node vector (level 0 = leaves).
    function automatic int unsigned lvl_off(input int unsigned k);
        int unsigned o;
        o = 0;
        for (int unsigned j = 0; j < k; j++) begin
            o = o + (PAD >> (2 * j));
        end
        return o;
    endfunction

    localparam int unsigned TOTAL = lvl_off(LEVELS + 1);

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] cap_result;
    logic             cap_carry;
    logic             cap_overflow;
    logic             capture;
    logic             commit;
    logic             accept;
    logic             zero;
    logic [TOTAL-1:0] nodes;

    // Condition table folded as base test on code[3:1], inverted by code[0] except for AL.
    function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] nzcv);
        logic n;
        logic z;
        logic c;
        logic v;
        logic base;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (code[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (code[0] && (code[3:1] != 3'd7)) begin
            return ~base;
        end
        return base;
    endfunction

    genvar gi;
    genvar gk;
    genvar gj;

    for (gi = 0; gi < PAD; gi++) begin : g_leaf
        if (gi < WIDTH) begin : g_bit
            assign nodes[gi] = cap_result[gi];
        end else begin : g_pad
            assign nodes[gi] = 1'b0;
        end
    end

    for (gk = 1; gk <= LEVELS; gk++) begin : g_lvl
        for (gj = 0; gj < (PAD >> (2 * gk)); gj++) begin : g_node
            assign nodes[lvl_off(gk) + gj] = |nodes[lvl_off(gk - 1) + 4 * gj +: 4];
        end
    end

    assign zero = ~nodes[TOTAL - 1];

    always_comb begin
        state_next = ST_IDLE;
        capture    = alu_valid & set_flags;
        commit     = (state == ST_PENDING);
        if (capture) begin
            state_next = ST_PENDING;
        end
        stall  = cond_req & (commit | capture);
        accept = cond_req & ~stall;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_result   <= '0;
            cap_carry    <= 1'b0;
            cap_overflow <= 1'b0;
            flags        <= '0;
            cond_valid   <= 1'b0;
            cond_taken   <= 1'b0;
        end else begin
            if (capture) begin
                cap_result   <= alu_result;
                cap_carry    <= alu_carry;
                cap_overflow <= alu_overflow;
            end
            if (commit) begin
                flags <= {cap_result[WIDTH-1], zero, cap_carry, cap_overflow};
            end
            cond_valid <= accept;
            if (accept) begin
                cond_taken <= eval_cond(cond_code, flags);
            end
        end
    end

endmodule
